// File: rtl/store_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : store_sequencer
// Brief    : Control-step FSM for the st instruction (fetch, Rb+C, write Ra).
// Revision : 1.0 - initial release
// ============================================================================
module store_sequencer #(
    parameter logic [4:0] ST_OPCODE  = 5'b00010,
    parameter logic [4:0] ALU_ADD    = 5'b00011,
    parameter int         WAIT_LIMIT = 15
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       start,
    input  logic [4:0] ir_opcode,
    input  logic       mem_ready,
    output logic       PCout,
    output logic       IncPC,
    output logic       MARin,
    output logic       PCin,
    output logic       read,
    output logic       write,
    output logic       RAMenable,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Gra,
    output logic       Grb,
    output logic       Rout,
    output logic       BAout,
    output logic       Yin,
    output logic       Cout,
    output logic       ZLOin,
    output logic       ZSelect,
    output logic       ZMuxEnable,
    output logic       ZMuxOut,
    output logic [4:0] aluControl,
    output logic       busy,
    output logic       done,
    output logic [1:0] fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_FAULT
    } state_t;

    typedef struct packed {
        logic       pc_out, inc_pc, mar_in, pc_in;
        logic       rd, wr, ram_en, mdr_in, mdr_out, ir_in;
        logic       gra, grb, r_out, ba_out, y_in, c_out;
        logic       zlo_in, z_sel, zmux_en, zmux_out;
        logic       busy, done;
        logic [4:0] alu;
    } ctrl_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

    state_t     state_q, state_d;
    logic [3:0] wait_q,  wait_d;
    logic [1:0] fault_q, fault_d;
    ctrl_t      ctrl_q,  ctrl_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_T0;
                fault_d = 2'b00;
            end
            S_T0: begin
                state_d = S_T1;
                wait_d  = 4'd0;
            end
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 2'b10;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_T2: state_d = S_T3;
            S_T3: begin
                if (ir_opcode != ST_OPCODE) begin
                    state_d = S_FAULT;
                    fault_d = 2'b01;
                end else begin
                    state_d = S_T4;
                end
            end
            S_T4: state_d = S_T5;
            S_T5: state_d = S_T6;
            S_T6: begin
                state_d = S_T7;
                wait_d  = 4'd0;
            end
            S_T7: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 2'b11;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        ctrl_d      = '0;
        ctrl_d.busy = (state_d != S_IDLE);
        case (state_d)
            S_T0: begin
                ctrl_d.pc_out = 1'b1;
                ctrl_d.mar_in = 1'b1;
                ctrl_d.inc_pc = 1'b1;
            end
            S_T1: begin
                ctrl_d.rd     = 1'b1;
                ctrl_d.ram_en = 1'b1;
                ctrl_d.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl_d.mdr_out = 1'b1;
                ctrl_d.ir_in   = 1'b1;
            end
            S_T3: begin
                ctrl_d.grb    = 1'b1;
                ctrl_d.ba_out = 1'b1;
                ctrl_d.y_in   = 1'b1;
            end
            S_T4: begin
                ctrl_d.c_out  = 1'b1;
                ctrl_d.alu    = ALU_ADD;
                ctrl_d.zlo_in = 1'b1;
            end
            S_T5: begin
                ctrl_d.zmux_en  = 1'b1;
                ctrl_d.zmux_out = 1'b1;
                ctrl_d.mar_in   = 1'b1;
            end
            S_T6: begin
                ctrl_d.gra    = 1'b1;
                ctrl_d.r_out  = 1'b1;
                ctrl_d.mdr_in = 1'b1;
            end
            S_T7: begin
                ctrl_d.wr     = 1'b1;
                ctrl_d.ram_en = 1'b1;
            end
            S_DONE:  ctrl_d.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            fault_q <= 2'b00;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCout      = ctrl_q.pc_out;
    assign IncPC      = ctrl_q.inc_pc;
    assign MARin      = ctrl_q.mar_in;
    assign PCin       = ctrl_q.pc_in;
    assign read       = ctrl_q.rd;
    assign write      = ctrl_q.wr;
    assign RAMenable  = ctrl_q.ram_en;
    assign MDRin      = ctrl_q.mdr_in;
    assign MDRout     = ctrl_q.mdr_out;
    assign IRin       = ctrl_q.ir_in;
    assign Gra        = ctrl_q.gra;
    assign Grb        = ctrl_q.grb;
    assign Rout       = ctrl_q.r_out;
    assign BAout      = ctrl_q.ba_out;
    assign Yin        = ctrl_q.y_in;
    assign Cout       = ctrl_q.c_out;
    assign ZLOin      = ctrl_q.zlo_in;
    assign ZSelect    = ctrl_q.z_sel;
    assign ZMuxEnable = ctrl_q.zmux_en;
    assign ZMuxOut    = ctrl_q.zmux_out;
    assign aluControl = ctrl_q.alu;
    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign fault      = fault_q;

endmodule
`default_nettype wire

// File: doc/store_sequencer.md
Name: store_sequencer

Overview:
Control-step sequencer for the store (st) instruction, the write-direction counterpart of the load control sequence. It fetches an instruction, forms the effective address Rb+C through the Y/ALU/Z path, and writes Ra to memory. It drives the DataPath control inputs one step per clock, replacing hand-timed stimulus, and waits on a memory-ready handshake for both the fetch and the write.

Parameters:
ST_OPCODE, 5'b00010, IR[31:27] value identifying st
ALU_ADD, 5'b00011, aluControl code for add
WAIT_LIMIT, 15, max cycles to wait for mem_ready before fault (4-bit counter)

Ports:
clock  in  1  system clock, all state changes on rising edge
clear  in  1  synchronous active-high reset
start  in  1  begin one st instruction (sampled in IDLE only)
ir_opcode  in  5  IR[31:27] from DataPath, valid from T3
mem_ready  in  1  memory completed current read/write this cycle
PCout, IncPC, MARin, PCin  out  1 each  PC/MAR controls
read, write, RAMenable, MDRin, MDRout, IRin  out  1 each  memory/MDR/IR controls
Gra, Grb, Rout, BAout, Yin, Cout  out  1 each  register-select and bus controls
ZLOin, ZSelect, ZMuxEnable, ZMuxOut  out  1 each  Z register controls
aluControl  out  5  ALU operation
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse on successful completion
fault  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 write timeout; held until next start

Behaviour:
- Moore FSM, all outputs decoded from registered state (glitch-free, valid whole cycle). clear has priority over all inputs: next edge -> IDLE, all outputs 0, aluControl=0, fault=00, wait counter=0. clear mid-instruction aborts immediately; no write is issued after the clear edge.
- States and outputs (unlisted outputs 0):
  IDLE: none. start=1 -> T0, fault cleared to 00.
  T0: PCout, MARin, IncPC. -> T1.
  T1: read, RAMenable, MDRin. Stay while mem_ready=0; mem_ready=1 -> T2.
  T2: MDRout, IRin. -> T3.
  T3: Grb, BAout, Yin. If ir_opcode!=ST_OPCODE -> FAULT (fault=01), else -> T4.
  T4: Cout, aluControl=ALU_ADD, ZLOin. -> T5.
  T5: ZSelect=0, ZMuxEnable, ZMuxOut, MARin. -> T6.
  T6: Gra, Rout, MDRin (read=0, MDR loads from bus). -> T7.
  T7: write, RAMenable. Stay while mem_ready=0; mem_ready=1 -> DONE.
  DONE: done=1 one cycle. -> IDLE.
  FAULT: busy=1, all controls 0, one cycle. -> IDLE.
- aluControl holds ALU_ADD only in T4; 0 elsewhere.
- Wait counter: reset to 0 on entering T1/T7, increments each cycle mem_ready=0 there. When count reaches WAIT_LIMIT with mem_ready still 0 -> FAULT, fault=10 (T1) or 11 (T7). mem_ready=1 on the same cycle as limit wins (success).
- Minimum latency start-to-done: start sampled edge N, T0 at N+1, DONE at N+9 with mem_ready tied high (10 states incl. DONE).
- start ignored while busy. start held high: new instruction begins the cycle after DONE/FAULT returns to IDLE.
- read and write never both 1; MARin never together with MDRin; Rout and BAout never together.
- mem_ready outside T1/T7 ignored.

Test Plan:
- clear=1 two cycles with start=1 -> every output 0, busy=0, fault=00; state stays IDLE.
- start pulse, mem_ready=1, ir_opcode=00010 -> T0..T7 exactly one cycle each, aluControl=00011 only in T4, done high cycle 9 after start edge, busy low cycle 10.
- mem_ready low 3 cycles in T1 and 2 in T7 -> T1 held 4 cycles, T7 held 3, write asserted all 3, done at cycle 14, fault=00.
- ir_opcode=00000 (ld) -> FAULT after T3, fault=01, done never asserts, write never asserts, T4-T7 not entered.
- mem_ready stuck low in T7 -> write held 15 cycles, then fault=11, IDLE next; mem_ready rising exactly on the 15th cycle -> done, fault=00.
- clear asserted during T6 -> next cycle IDLE, write never asserts, all outputs 0; subsequent start runs normally.
